// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word and fetch-state types
//
// Purpose : common types for the fetch stage and its bench.
//   word_t        : 32-bit machine word / address
//   fetch_state_t : FETCH, HOLD, DISCARD, HALTED
//   pc_next()     : PC + 4 with silent 32-bit wrap-around
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2,
    HALTED  = 2'd3
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

  // Unsigned add; the carry out of bit 31 is intentionally discarded.
  function automatic word_t pc_next(input word_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-cache request/response bundle
//
// Purpose : groups the fetch <-> icache handshake.
// Signals :
//   iREN  - read request from fetch
//   iaddr - request address (the fetch PC)
//   ihit  - icache returns data for iaddr this cycle
//   iload - instruction word, valid with ihit
// Modports:
//   master - fetch side (drives iREN/iaddr)
//   slave  - icache side (drives ihit/iload)
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  ihit;
  word_t iload;

  modport master (output iREN, output iaddr, input ihit, input iload);
  modport slave  (input iREN, input iaddr, output ihit, output iload);

endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with stall buffer and redirect discard
//
// Purpose : fetches one instruction per icache hit into the fetch latch,
//           absorbs decode stalls with a one-entry buffer, drops the
//           in-flight word on a redirect, and stops permanently on halt.
// Ports   :
//   CLK           - clock, rising edge
//   RST           - synchronous active-high reset
//   en            - fetch latch enable (0 = decode stalled)
//   redirect      - taken branch/jump, redirect_pc is the new target
//   redirect_pc   - redirect target address
//   halt          - halt decoded; stop fetching
//   imem          - icache bundle (master side): iREN, iaddr, ihit, iload
//   out_instr     - registered instruction to the fetch latch
//   out_pc_plus_4 - registered PC+4 of out_instr
//   out_valid     - out_instr is a real instruction
//   halted        - stage is in HALTED
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic                 redirect,
  input  word_t                redirect_pc,
  input  logic                 halt,
  fetch_stage_if.master        imem,
  output word_t                out_instr,
  output word_t                out_pc_plus_4,
  output logic                 out_valid,
  output logic                 halted
);

  fetch_state_t state, state_n;
  word_t        pc, pc_n;
  word_t        pc_inc;
  word_t        buf_instr, buf_instr_n;
  word_t        buf_pc4, buf_pc4_n;
  word_t        target, target_n;
  word_t        out_instr_n, out_pc4_n;
  logic         out_valid_n;
  logic         bubble;

  assign pc_inc = pc_next(pc);

  // halt withdraws the request in the same cycle; the icache tolerates
  // an aborted read, so no handshake is needed to cancel it.
  assign imem.iREN  = ((state == FETCH) || (state == DISCARD)) && !halt;
  assign imem.iaddr = pc;
  assign halted     = (state == HALTED);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= FETCH;
      pc            <= PC_INIT;
      buf_instr     <= '0;
      buf_pc4       <= '0;
      target        <= '0;
      out_instr     <= '0;
      out_pc_plus_4 <= '0;
      out_valid     <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      buf_instr     <= buf_instr_n;
      buf_pc4       <= buf_pc4_n;
      target        <= target_n;
      out_instr     <= out_instr_n;
      out_pc_plus_4 <= out_pc4_n;
      out_valid     <= out_valid_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    buf_instr_n = buf_instr;
    buf_pc4_n   = buf_pc4;
    target_n    = target;
    out_instr_n = out_instr;
    out_pc4_n   = out_pc_plus_4;
    out_valid_n = out_valid;
    bubble      = 1'b0;

    if (halt) begin
      state_n = HALTED;
      bubble  = en;
    end else begin
      unique case (state)
        FETCH: begin
          if (redirect) begin
            bubble = en;
            if (imem.ihit) begin
              // Word for the old path arrived: drop it and restart at target.
              pc_n = redirect_pc;
            end else begin
              // Request still outstanding at the old PC; iaddr must stay
              // put until it completes, so park the target.
              target_n = redirect_pc;
              state_n  = DISCARD;
            end
          end else if (imem.ihit) begin
            if (en) begin
              out_instr_n = imem.iload;
              out_pc4_n   = pc_inc;
              out_valid_n = 1'b1;
              pc_n        = pc_inc;
            end else begin
              buf_instr_n = imem.iload;
              buf_pc4_n   = pc_inc;
              state_n     = HOLD;
            end
          end else begin
            bubble = en;
          end
        end

        HOLD: begin
          if (redirect) begin
            buf_instr_n = '0;
            buf_pc4_n   = '0;
            pc_n        = redirect_pc;
            state_n     = FETCH;
            bubble      = en;
          end else if (en) begin
            out_instr_n = buf_instr;
            out_pc4_n   = buf_pc4;
            out_valid_n = 1'b1;
            pc_n        = pc_inc;
            state_n     = FETCH;
          end
        end

        DISCARD: begin
          // Nothing useful reaches the latch while waiting out the stale read.
          bubble = en;
          if (imem.ihit) begin
            // A redirect arriving with the hit is the newest target.
            pc_n     = redirect ? redirect_pc : target;
            target_n = '0;
            state_n  = FETCH;
          end else if (redirect) begin
            target_n = redirect_pc;
          end
        end

        HALTED: begin
          bubble = en;
        end

        default: begin
          state_n = FETCH;
        end
      endcase
    end

    if (bubble) begin
      out_valid_n = 1'b0;
      out_instr_n = '0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic  CLK;
  logic  RST;
  logic  en;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t out_instr;
  word_t out_pc_plus_4;
  logic  out_valid;
  logic  halted;

  fetch_stage_if imem ();

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .en            (en),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .imem          (imem),
    .out_instr     (out_instr),
    .out_pc_plus_4 (out_pc_plus_4),
    .out_valid     (out_valid),
    .halted        (halted)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic rd, input word_t rp,
                       input logic h, input logic ih, input word_t il);
    @(negedge CLK);
    RST = r; en = e; redirect = rd; redirect_pc = rp; halt = h;
    imem.ihit = ih; imem.iload = il;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Directed vectors: inputs, expected request before the edge, expected latch after it.
  typedef struct {
    logic  rst, en, red;
    word_t rpc;
    logic  halt, ihit;
    word_t iload;
    logic  chk_pre, e_iren;
    word_t e_iaddr;
    logic  e_valid;
    word_t e_instr, e_pc4;
    logic  e_halted;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic rd, word_t rp, logic h, logic ih, word_t il,
                              logic cp, logic ir, word_t ia, logic v, word_t ins, word_t p4);
    vec_t t;
    t.rst = r; t.en = e; t.red = rd; t.rpc = rp; t.halt = h; t.ihit = ih; t.iload = il;
    t.chk_pre = cp; t.e_iren = ir; t.e_iaddr = ia;
    t.e_valid = v; t.e_instr = ins; t.e_pc4 = p4; t.e_halted = 1'b0;
    return t;
  endfunction

  // Reference model: pending work is kept as queues; the mode is implied by what is pending.
  typedef struct { word_t instr; word_t pc4; } held_t;
  held_t m_held[$];
  word_t m_tgt[$];
  word_t m_pc;
  logic  m_halted;
  word_t m_instr, m_pc4;
  logic  m_valid;

  function automatic void m_reset();
    m_held.delete(); m_tgt.delete();
    m_pc = 32'h0; m_halted = 1'b0;
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endfunction

  function automatic logic m_iren(input logic h);
    return !h && !m_halted && (m_held.size() == 0);
  endfunction

  function automatic void m_step(logic r, logic e, logic rd, word_t rp, logic h, logic ih, word_t il);
    logic  bub;
    held_t x;
    bub = 1'b0;
    if (r) begin
      m_reset();
      return;
    end
    if (h) begin
      m_halted = 1'b1; m_held.delete(); m_tgt.delete(); bub = e;
    end else if (m_halted) begin
      bub = e;
    end else if (m_held.size() != 0) begin
      if (rd) begin
        m_held.delete(); m_pc = rp; bub = e;
      end else if (e) begin
        x = m_held.pop_front();
        m_instr = x.instr; m_pc4 = x.pc4; m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else if (m_tgt.size() != 0) begin
      bub = e;
      if (rd) m_tgt[0] = rp;
      if (ih) m_pc = m_tgt.pop_front();
    end else begin
      if (rd) begin
        bub = e;
        if (ih) m_pc = rp;
        else m_tgt.push_back(rp);
      end else if (ih) begin
        if (e) begin
          m_instr = il; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end else begin
          x.instr = il; x.pc4 = m_pc + 32'd4;
          m_held.push_back(x);
        end
      end else begin
        bub = e;
      end
    end
    if (bub) begin
      m_valid = 1'b0; m_instr = 32'h0;
    end
  endfunction

  vec_t tbl[$];

  initial begin
    RST = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    imem.ihit = 1'b0; imem.iload = '0;

    //                rst en rd rpc           h ih iload          pre ir iaddr        v  instr         pc4
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'hA000_0000, 1, 1, 32'h0,       1, 32'hA000_0000, 32'h4));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'hA000_0001, 1, 1, 32'h4,       1, 32'hA000_0001, 32'h8));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'hA000_0002, 1, 1, 32'h8,       1, 32'hA000_0002, 32'hC));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'hC,        0, 32'h0,        32'hC));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'hA000_0003, 1, 1, 32'hC,       1, 32'hA000_0003, 32'h10));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'hB000_0000, 1, 1, 32'h10,      1, 32'hA000_0003, 32'h10));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h10,       1, 32'hA000_0003, 32'h10));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'hFFFF_FFFF, 1, 0, 32'h10,      1, 32'hA000_0003, 32'h10));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h10,       1, 32'hB000_0000, 32'h14));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h14,       0, 32'h0,        32'h14));
    tbl.push_back(mk(0, 1, 1, 32'h8,        0, 1, 32'hCC,       1, 1, 32'h14,       0, 32'h0,        32'h14));
    tbl.push_back(mk(0, 1, 1, 32'h40,       0, 0, 32'h0,        1, 1, 32'h8,        0, 32'h0,        32'h14));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h8,        0, 32'h0,        32'h14));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'hDD,       1, 1, 32'h8,        0, 32'h0,        32'h14));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'hE0,       1, 1, 32'h40,       1, 32'hE0,       32'h44));
    tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 0, 1, 32'h11,      1, 1, 32'h44,       0, 32'h0,        32'h44));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'hF0,       1, 1, 32'hFFFF_FFFC, 1, 32'hF0,      32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h22,       1, 1, 32'h0,        0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 1, 32'h80,       0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'h33,       1, 1, 32'h80,       1, 32'h33,       32'h84));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].red, tbl[i].rpc, tbl[i].halt, tbl[i].ihit, tbl[i].iload);
      if (tbl[i].chk_pre) begin
        chk($sformatf("vec%0d_iREN", i), imem.iREN, tbl[i].e_iren);
        chk($sformatf("vec%0d_iaddr", i), imem.iaddr, tbl[i].e_iaddr);
      end
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_out_instr", i), out_instr, tbl[i].e_instr);
      chk($sformatf("vec%0d_out_pc_plus_4", i), out_pc_plus_4, tbl[i].e_pc4);
      chk($sformatf("vec%0d_halted", i), halted, tbl[i].e_halted);
    end

    // Halt and redirect together: halt wins, request drops at once.
    drive(0, 1, 1, 32'h100, 1, 1, 32'h44);
    chk("halt_iREN_same_cycle", imem.iREN, 1'b0);
    tick();
    chk("halt_halted", halted, 1'b1);
    chk("halt_out_valid", out_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1'($urandom_range(1)), 32'h200, 0, 1, 32'h77);
      chk("halted_iREN", imem.iREN, 1'b0);
      tick();
      chk("halted_stays", halted, 1'b1);
      chk("halted_out_valid", out_valid, 1'b0);
    end
    drive(1, 1, 0, 32'h0, 0, 1, 32'h0);
    tick();
    chk("halt_reset_halted", halted, 1'b0);
    chk("halt_reset_out_valid", out_valid, 1'b0);
    drive(0, 1, 0, 32'h0, 0, 1, 32'h60);
    chk("halt_reset_iREN", imem.iREN, 1'b1);
    chk("halt_reset_iaddr", imem.iaddr, 32'h0);
    tick();

    // Reset while waiting out a stale read: the next hit must be delivered, not dropped.
    drive(0, 1, 1, 32'h200, 0, 0, 32'h0);
    tick();
    drive(1, 1, 0, 32'h0, 0, 1, 32'h55);
    tick();
    drive(0, 1, 0, 32'h0, 0, 1, 32'h66);
    chk("discard_reset_iaddr", imem.iaddr, 32'h0);
    tick();
    chk("discard_reset_out_valid", out_valid, 1'b1);
    chk("discard_reset_out_instr", out_instr, 32'h66);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    chk("discard_reset_next_iaddr", imem.iaddr, 32'h4);

    // Randomized traffic against the reference model.
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      logic  r, e, rd, h, ih;
      word_t rp, il;
      r  = ($urandom_range(99) < 1);
      e  = ($urandom_range(99) < 75);
      rd = ($urandom_range(99) < 10);
      h  = ($urandom_range(99) < 2);
      ih = ($urandom_range(99) < 50);
      rp = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      il = $urandom();
      drive(r, e, rd, rp, h, ih, il);
      chk("rnd_iREN", imem.iREN, m_iren(h));
      chk("rnd_iaddr", imem.iaddr, m_pc);
      tick();
      m_step(r, e, rd, rp, h, ih, il);
      chk("rnd_out_valid", out_valid, m_valid);
      chk("rnd_out_instr", out_instr, m_instr);
      chk("rnd_out_pc_plus_4", out_pc_plus_4, m_pc4);
      chk("rnd_halted", halted, m_halted);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
